muldiv_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 32 +++
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU and the multi-cycle mul/div sequencer.
//   - 4-bit ALU opcodes (ADD..SLTU, NOP = 0 when the ALU is not claimed)
//   - muldiv_op_e: MUL / MULHU / DIVU / REMU encoding of the 2-bit op field
//   - md_state_e : sequencer FSM state encoding
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL / MULHU / DIVU / REMU controller that borrows the
// shared ALU for one ADD (multiply) or SUB (restoring divide) per cycle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; ALU not claimed
// RUN     | 32 iterations, cnt 0..31; owns the ALU (alu_sel), stalls core
// DONE    | one-cycle done pulse; result holds until the next accept
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        request (sampled only in IDLE) and operation select
//   rs1, rs2         multiplicand/dividend, multiplier/divisor
//   busy, done       RUN decode, DONE decode
//   result           registered result
//   alu_sel          ALU operand-mux select at core top level
//   alu_a/b, alu_op  ALU operands and opcode, zero outside RUN
//   alu_result       combinational ALU return
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result
);

  localparam int CW = $clog2(ITER);

  md_state_e       state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // hi doubles as the divide remainder, lo as the quotient, mcand as divisor
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] sh;
  logic            carry;
  logic            ge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = ALU_NOP;
    sh       = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    carry    = 1'b0;
    ge       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Multiply and divide load the shared registers identically.
          op_d    = muldiv_op_e'(op);
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = rs1;
          mcand_d = rs2;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!op_q[1]) begin
          alu_a  = hi_q;
          alu_b  = lo_q[0] ? mcand_q : '0;
          alu_op = ALU_ADD;
          // Wrap-around of hi + addend recovers the 33rd sum bit.
          carry  = (alu_result < hi_q);
          hi_d   = {carry, alu_result[XLEN-1:1]};
          lo_d   = {alu_result[0], lo_q[XLEN-1:1]};
        end else begin
          alu_a  = sh;
          alu_b  = mcand_q;
          alu_op = ALU_SUB;
          // rem[31] set means the shifted remainder is a 33-bit value that
          // always exceeds the divisor; the mod-2^32 difference is exact.
          ge     = hi_q[XLEN-1] | (sh >= mcand_q);
          hi_d   = ge ? alu_result : sh;
          lo_d   = {lo_q[XLEN-2:0], ge};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = ST_DONE;
          unique case (op_q)
            MD_MUL:   result_d = lo_d;
            MD_MULHU: result_d = hi_d;
            MD_DIVU:  result_d = lo_d;
            MD_REMU:  result_d = hi_d;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_RUN);
  assign alu_sel = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign result  = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done, alu_sel;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stand-in for the core ALU: only ADD and SUB are needed here.
  assign alu_result = (alu_op == 4'b0001) ? alu_a + alu_b :
                      (alu_op == 4'b0010) ? alu_a - alu_b : 32'h0;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result), .alu_sel(alu_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Wait (bounded) for done, counting busy cycles and ALU-control misbehaviour.
  task automatic wait_done(input logic [1:0] o, output int busy_n,
                           output logic [31:0] res, output bit ok, output int ctl_bad);
    logic [3:0] exp_op;
    exp_op  = o[1] ? 4'b0010 : 4'b0001;
    busy_n  = 0;
    ok      = 0;
    ctl_bad = 0;
    res     = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_n++;
        if (!alu_sel || alu_op !== exp_op) ctl_bad++;
      end else if (alu_sel || alu_op !== 4'b0000 || alu_a !== 0 || alu_b !== 0) begin
        ctl_bad++;
      end
      if (done) begin
        res = result;
        ok  = 1;
        if (busy) ctl_bad++;
        break;
      end
    end
  endtask

  task automatic check_done(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b);
    int          busy_n, ctl_bad;
    logic [31:0] res, exp;
    bit          ok;
    exp = ref_md(o, a, b);
    wait_done(o, busy_n, res, ok, ctl_bad);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd32);
    chk({tag, "_alu_ctrl"}, 32'(ctl_bad), 32'd0);
    chk({tag, "_result"}, res, exp);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
    chk({tag, "_result_hold"}, result, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    check_done(tag, o, a, b);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; rs1 = 0; rs2 = 0;
    #12;
    chk("rst_busy",    {31'h0, busy},    32'd0);
    chk("rst_done",    {31'h0, done},    32'd0);
    chk("rst_alu_sel", {31'h0, alu_sel}, 32'd0);
    chk("rst_result",  result,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul7x6",   2'd0, 32'd7, 32'd6);
    run_op("mul_ff",   2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu100",  2'd2, 32'd100, 32'd7);
    run_op("remu100",  2'd3, 32'd100, 32'd7);
    run_op("divu_ff1", 2'd2, 32'hFFFF_FFFF, 32'd1);
    run_op("remu_ff1", 2'd3, 32'hFFFF_FFFF, 32'd1);
    run_op("divu_8k3", 2'd2, 32'h8000_0000, 32'd3);
    run_op("remu_8k3", 2'd3, 32'h8000_0000, 32'd3);
    run_op("divu_z",   2'd2, 32'h1234_5678, 32'd0);
    run_op("remu_z",   2'd3, 32'h1234_5678, 32'd0);
    chk("divu_z_lit", ref_md(2'd2, 32'h1234_5678, 32'd0), 32'hFFFF_FFFF);

    // start held high with changing operands through RUN and DONE
    start = 1'b1; op = 2'd0; rs1 = 32'd7; rs2 = 32'd6;
    @(posedge clk);
    #1 op = 2'd2; rs1 = 32'd100; rs2 = 32'd7;
    begin
      int busy_n, ctl_bad; logic [31:0] res; bit ok;
      wait_done(2'd0, busy_n, res, ok, ctl_bad);
      chk("hold_first_seen", 32'(ok), 32'd1);
      chk("hold_first_busy", 32'(busy_n), 32'd32);
      chk("hold_first_res", res, 32'd42);
    end
    @(negedge clk);
    chk("hold_idle_done", {31'h0, done}, 32'd0);
    chk("hold_idle_busy", {31'h0, busy}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    check_done("hold_second", 2'd2, 32'd100, 32'd7);

    // asynchronous reset in the middle of RUN
    start = 1'b1; op = 2'd1; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_busy_before", {31'h0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",    {31'h0, busy},    32'd0);
    chk("mid_rst_alu_sel", {31'h0, alu_sel}, 32'd0);
    chk("mid_rst_done",    {31'h0, done},    32'd0);
    chk("mid_rst_result",  result,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_mul", 2'd0, 32'd3, 32'd5);

    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), o, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
